// File: rtl/clock_core_multi_alarm.sv
// clock_core_multi_alarm
// Time-of-day core. It contains a seconds prescaler, 24-hour HH:MM:SS counters
// with manual hour/minute adjust, 12/24-hour BCD display digits with AM/PM,
// and NUM_ALARMS independent alarm channels. Each channel has snooze and an
// automatic ring timeout.
module clock_core_multi_alarm #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hup,
  input  logic                  mup,
  input  logic                  fmt_12,
  input  logic                  alm_wr,
  input  logic [IDX_W-1:0]      alm_idx,
  input  logic [4:0]            alm_hr,
  input  logic [5:0]            alm_min,
  input  logic                  alm_en,
  input  logic                  snooze,
  input  logic                  alm_stop,
  output logic [4:0]            hr,
  output logic [5:0]            min,
  output logic [5:0]            sec,
  output logic [3:0]            hr_tens,
  output logic [3:0]            hr_ones,
  output logic [3:0]            min_tens,
  output logic [3:0]            min_ones,
  output logic                  is_pm,
  output logic [NUM_ALARMS-1:0] alm_ring,
  output logic                  alm_led
);

  localparam int               CNT_W     = $clog2(TICK_DIV);
  localparam int               SNZ_TICKS = SNOOZE_MIN * 60;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       RING_LAST = 8'(RING_SEC - 1);
  localparam logic [11:0]      SNZ_LAST  = 12'(SNZ_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RING = 2'd1,
    ST_SNZ  = 2'd2
  } alm_state_e;

  // ------------------------------------------------------------------
  // Prescaler and time-of-day counters
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       hr_q, hr_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  // The time registers were just advanced by a tick. Only such a time
  // may trigger an alarm. A time reached by manual adjust may not.
  logic             tick_seen_q, tick_seen_d;
  logic             sec_tick;

  assign sec_tick = (cnt_q == CNT_LAST);

  // Next prescaler count: it wraps to zero in the tick cycle.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (sec_tick) begin
      cnt_d = '0;
    end
  end

  // Next time: the tick carry chain has priority, and adjust applies only without a tick.
  always_comb begin
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    tick_seen_d = sec_tick;
    if (sec_tick) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      if (hup) begin
        hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
      end
      if (mup) begin
        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      end
    end
  end

  // Registers for the prescaler, the time of day and the tick history.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      hr_q        <= 5'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      tick_seen_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tick_seen_q <= tick_seen_d;
    end
  end

  assign hr  = hr_q;
  assign min = min_q;
  assign sec = sec_q;

  // ------------------------------------------------------------------
  // Display digits
  // ------------------------------------------------------------------
  logic [4:0] disp_hr;

  // Hour shown on the display. In 12-hour mode it is folded into 1..12.
  always_comb begin
    disp_hr = hr_q;
    if (fmt_12) begin
      if (hr_q == 5'd0) begin
        disp_hr = 5'd12;
      end else if (hr_q > 5'd12) begin
        disp_hr = hr_q - 5'd12;
      end
    end
  end

  assign hr_tens  = 4'(disp_hr / 5'd10);
  assign hr_ones  = 4'(disp_hr % 5'd10);
  assign min_tens = 4'(min_q / 6'd10);
  assign min_ones = 4'(min_q % 6'd10);
  assign is_pm    = (hr_q >= 5'd12);

  // ------------------------------------------------------------------
  // Alarm channels
  // ------------------------------------------------------------------
  logic [NUM_ALARMS-1:0] ring_next;

  generate
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alm
      alm_state_e  state_q, state_d;
      logic [4:0]  a_hr_q, a_hr_d;
      logic [5:0]  a_min_q, a_min_d;
      logic        a_en_q, a_en_d;
      logic [7:0]  ring_cnt_q, ring_cnt_d;
      logic [11:0] snz_cnt_q, snz_cnt_d;
      logic        ring_q;
      logic        wr_hit;
      logic        snz_hit;
      logic        match;

      assign wr_hit  = alm_wr && (alm_idx == IDX_W'(gi));
      assign snz_hit = snooze && (alm_idx == IDX_W'(gi));
      assign match   = tick_seen_q && a_en_q && (sec_q == 6'd0) &&
                       (hr_q == a_hr_q) && (min_q == a_min_q);

      // Channel next state. Priority: write, stop, snooze, timeout, match.
      always_comb begin
        state_d    = state_q;
        a_hr_d     = a_hr_q;
        a_min_d    = a_min_q;
        a_en_d     = a_en_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        if (wr_hit) begin
          a_hr_d     = alm_hr;
          a_min_d    = alm_min;
          a_en_d     = alm_en;
          state_d    = ST_IDLE;
          ring_cnt_d = 8'd0;
          snz_cnt_d  = 12'd0;
        end else if (alm_stop) begin
          state_d = ST_IDLE;
        end else begin
          unique case (state_q)
            ST_IDLE: begin
              if (match) begin
                state_d    = ST_RING;
                ring_cnt_d = 8'd0;
              end
            end
            ST_RING: begin
              if (snz_hit) begin
                state_d   = ST_SNZ;
                snz_cnt_d = 12'd0;
              end else if (sec_tick) begin
                if (ring_cnt_q == RING_LAST) begin
                  state_d = ST_IDLE;
                end else begin
                  ring_cnt_d = ring_cnt_q + 8'd1;
                end
              end
            end
            ST_SNZ: begin
              if (sec_tick) begin
                if (snz_cnt_q == SNZ_LAST) begin
                  state_d    = ST_RING;
                  ring_cnt_d = 8'd0;
                end else begin
                  snz_cnt_d = snz_cnt_q + 12'd1;
                end
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      end

      assign ring_next[gi] = (state_d == ST_RING);

      // Channel registers. The ring flag is registered together with the state.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_q    <= ST_IDLE;
          a_hr_q     <= 5'd0;
          a_min_q    <= 6'd0;
          a_en_q     <= 1'b0;
          ring_cnt_q <= 8'd0;
          snz_cnt_q  <= 12'd0;
          ring_q     <= 1'b0;
        end else begin
          state_q    <= state_d;
          a_hr_q     <= a_hr_d;
          a_min_q    <= a_min_d;
          a_en_q     <= a_en_d;
          ring_cnt_q <= ring_cnt_d;
          snz_cnt_q  <= snz_cnt_d;
          ring_q     <= ring_next[gi];
        end
      end

      assign alm_ring[gi] = ring_q;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Alarm LED
  // ------------------------------------------------------------------
  logic led_q, led_d;

  // The LED blinks on ticks while something rings and drops as soon as nothing will.
  always_comb begin
    led_d = led_q;
    if (!(|ring_next)) begin
      led_d = 1'b0;
    end else if (sec_tick && (|alm_ring)) begin
      led_d = ~led_q;
    end
  end

  // LED register.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
    end
  end

  assign alm_led = led_q;

endmodule
